// File: rtl/add_pkg.sv
// Shared defaults and helpers for the sliced, pipelined adder.
package add_pkg;

    localparam int WIDTH_DEF  = 41;
    localparam int STAGES_DEF = 3;
    localparam int MAX_WIDTH  = 128;

    function automatic int slice_w(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE_W-bit ripple-carry adder built from full_adder cells.
module add_slice #(
    parameter int SLICE_W = 14
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[SLICE_W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract: one carry slice per stage, operands skewed in and
// result slices de-skewed out through the same per-stage registers.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_one,
    input  logic [WIDTH-1:0] i_data_two,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);

    localparam int SW = slice_w(WIDTH, STAGES);
    // Operands are zero-padded to a whole number of slices; the top slice then
    // holds the remainder bits and the carry out of bit WIDTH-1 lands at bit WIDTH.
    localparam int PW = SW * STAGES;

    if (WIDTH < 2 || WIDTH > MAX_WIDTH || STAGES < 1 || STAGES > WIDTH) begin : g_bad_param
        $error("add_pipe: WIDTH or STAGES out of range");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic [PW-1:0]    a_pad;
    logic [PW-1:0]    b_pad;
    logic             cin_eff;

    // Stage k register: low (k+1)*SW bits are finished result, upper bits are
    // still operand A; y carries operand B for the slices not yet consumed.
    logic [PW-1:0] x_p   [STAGES];
    logic [PW-1:0] y_p   [STAGES];
    logic          c_p   [STAGES];
    logic          vld_p [STAGES];

    logic [PW-1:0] x_src [STAGES];
    logic [PW-1:0] y_src [STAGES];
    logic          c_src [STAGES];
    logic [PW-1:0] x_nxt [STAGES];
    logic          c_nxt [STAGES];

    assign advance = !vld_p[STAGES-1] || i_ready;
    assign o_ready = advance;

    assign b_eff   = i_sub ? ~i_data_two : i_data_two;
    assign cin_eff = i_sub ? 1'b1 : i_carry;
    assign a_pad   = PW'(i_data_one);
    assign b_pad   = PW'(b_eff);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [PW-1:0] MASK = PW'({SW{1'b1}}) << (k * SW);

        logic [SW-1:0] sum;
        logic          cout;

        if (k == 0) begin : g_first
            assign x_src[k] = a_pad;
            assign y_src[k] = b_pad;
            assign c_src[k] = cin_eff;
        end else begin : g_next
            assign x_src[k] = x_p[k-1];
            assign y_src[k] = y_p[k-1];
            assign c_src[k] = c_p[k-1];
        end

        add_slice #(.SLICE_W(SW)) u_slice (
            .a    (x_src[k][k*SW +: SW]),
            .b    (y_src[k][k*SW +: SW]),
            .cin  (c_src[k]),
            .sum  (sum),
            .cout (cout)
        );

        assign x_nxt[k] = (x_src[k] & ~MASK) | (PW'(sum) << (k * SW));
        assign c_nxt[k] = cout;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                x_p[k]   <= '0;
                y_p[k]   <= '0;
                c_p[k]   <= 1'b0;
            end
        end else if (advance) begin
            vld_p[0] <= i_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                x_p[k] <= x_nxt[k];
                y_p[k] <= y_src[k];
                c_p[k] <= c_nxt[k];
            end
        end
    end

    // Output stage is the last pipeline register.
    assign o_valid = vld_p[STAGES-1];
    assign o_data  = x_p[STAGES-1][WIDTH-1:0];

    if (PW > WIDTH) begin : g_carry_pad
        assign o_carry = x_p[STAGES-1][WIDTH];
    end else begin : g_carry_slice
        assign o_carry = c_p[STAGES-1];
    end

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: default 41-bit/3-stage instance plus an 8-bit/1-stage instance.
module tb_add_pipe;

    localparam int W = 41;
    localparam int S = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         vld_in, rdy_out, cin_in, sub_in, vld_out, rdy_in, cry_out;
    logic [W-1:0] a_in, b_in, dat_out;

    logic       v8_in, r8_out, c8_in, s8_in, v8_out, c8_out;
    logic [7:0] a8, b8, d8_out;

    add_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (vld_in),
        .o_ready    (rdy_out),
        .i_data_one (a_in),
        .i_data_two (b_in),
        .i_carry    (cin_in),
        .i_sub      (sub_in),
        .o_valid    (vld_out),
        .i_ready    (rdy_in),
        .o_data     (dat_out),
        .o_carry    (cry_out)
    );

    add_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (v8_in),
        .o_ready    (r8_out),
        .i_data_one (a8),
        .i_data_two (b8),
        .i_carry    (c8_in),
        .i_sub      (s8_in),
        .o_valid    (v8_out),
        .i_ready    (1'b1),
        .o_data     (d8_out),
        .o_carry    (c8_out)
    );

    typedef struct {
        logic [W:0] res;
        int         t_in;
    } exp_t;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    exp_t sb[$];
    int   out_t[$];
    bit   chk_lat  = 1'b1;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are judged mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (vld_out && rdy_in) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(vld_out), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'({cry_out, dat_out}), 64'(e.res));
                    if (chk_lat) chk("latency", 64'(cyc - e.t_in), 64'(S));
                    out_t.push_back(cyc);
                end
            end
            if (vld_in && rdy_out)
                sb.push_back('{model(a_in, b_in, cin_in, sub_in), cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic [63:0] r;
        r      = {$urandom, $urandom};
        vld_in = 1'b0;
        a_in   = r[W-1:0];
        b_in   = r[63:64-W];
        if (rand_rdy) rdy_in = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub);
        bit acc;
        acc    = 1'b0;
        vld_in = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = ci;
        sub_in = sub;
        for (int i = 0; i < 50; i++) begin
            if (rand_rdy) rdy_in = 1'($urandom_range(0, 1));
            #1;
            acc = rdy_out;
            step();
            if (acc) break;
        end
        chk("send_accept", 64'(acc), 64'd1);
        vld_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            idle();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        logic [63:0]  r;
        int           cnt;

        vld_in = 1'b0; rdy_in = 1'b1; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        v8_in  = 1'b0; a8 = '0; b8 = '0; c8_in = 1'b0; s8_in = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(vld_out), 64'd0);
        chk("rst_data",  64'(dat_out), 64'd0);
        chk("rst_carry", 64'(cry_out), 64'd0);
        chk("rst_valid8", 64'(v8_out), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(rdy_out), 64'd1);
        chk("ready8_after_rst", 64'(r8_out), 64'd1);
        step();

        // Single-stage 8-bit instance.
        v8_in = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8_in = 1'b1; s8_in = 1'b0;
        step();
        chk("w8_valid", 64'(v8_out), 64'd1);
        chk("w8_sum",   64'({c8_out, d8_out}), 64'h101);
        a8 = 8'h10; b8 = 8'h20; c8_in = 1'b1; s8_in = 1'b1;
        step();
        v8_in = 1'b0;
        chk("w8_sub", 64'({c8_out, d8_out}), 64'h0F0);
        step();
        chk("w8_drop", 64'(v8_out), 64'd0);

        // Carry crossing both slice boundaries.
        send({W{1'b1}}, W'(1), 1'b0, 1'b0);
        drain(20);

        // Back-to-back mixed add/sub stream.
        send(W'(5), W'(7), 1'b0, 1'b1);
        send(W'(7), W'(5), 1'b1, 1'b1);
        send(W'(1), W'(1), 1'b0, 1'b0);
        send(W'(2), W'(2), 1'b1, 1'b0);
        send(W'(9), W'(3), 1'b0, 1'b1);
        send(W'('h100), W'(1), 1'b0, 1'b0);
        drain(20);

        // Stall with one result at the output and two behind it.
        rdy_in = 1'b0;
        send(W'('h123456789), W'('h1111), 1'b1, 1'b0);
        send(W'(3), W'(4), 1'b0, 1'b1);
        send(W'('h1FFFF0000), W'('h10000), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (vld_out) break;
            idle();
        end
        chk("stall_first_valid", 64'(vld_out), 64'd1);
        held    = dat_out;
        chk_lat = 1'b0;
        repeat (5) begin
            chk("stall_ready", 64'(rdy_out), 64'd0);
            chk("stall_valid", 64'(vld_out), 64'd1);
            chk("stall_hold",  64'(dat_out), 64'(held));
            idle();
        end
        out_t.delete();
        rdy_in = 1'b1;
        drain(20);
        chk("stall_count", 64'(out_t.size()), 64'd3);
        if (out_t.size() == 3) begin
            chk("stall_consec1", 64'(out_t[1] - out_t[0]), 64'd1);
            chk("stall_consec2", 64'(out_t[2] - out_t[1]), 64'd1);
        end
        chk_lat = 1'b1;

        // Asynchronous reset with operations in flight.
        send(W'('hABCDE), W'('h12345), 1'b0, 1'b0);
        send(W'('h77), W'('h11), 1'b0, 1'b1);
        step();
        chk("pre_rst_valid", 64'(vld_out), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clr_valid", 64'(vld_out), 64'd0);
        chk("async_clr_data",  64'(dat_out), 64'd0);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst2", 64'(rdy_out), 64'd1);
        cnt = 0;
        repeat (10) begin
            if (vld_out) cnt++;
            idle();
        end
        chk("no_ghost_out", 64'(cnt), 64'd0);

        // Random stream with random back-pressure and input gaps.
        rand_rdy = 1'b1;
        chk_lat  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            r = {$urandom, $urandom};
            send(r[W-1:0], W'({$urandom, $urandom}), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        drain(300);
        rand_rdy = 1'b0;
        rdy_in   = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
